// File: rtl/issue_queue_select.sv
// Issue queue for one FU column: holds uops until both sources are woken, issues the oldest ready one.
// Latency: dispatch or wakeup at edge N can issue at cycle N+1; select is combinational from state.
// Backpressure: disp_ready drops when full or flushing; a selection waits in place for issue_ready.
module issue_queue_select #(
    parameter int NUM_ENTRIES = 8,
    parameter int TAG_W       = 6,
    parameter int PAYLOAD_W   = 64,
    parameter int NUM_WAKE    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [PAYLOAD_W-1:0]             disp_payload,
    input  logic [TAG_W-1:0]                 disp_src1_tag,
    input  logic                             disp_src1_rdy,
    input  logic [TAG_W-1:0]                 disp_src2_tag,
    input  logic                             disp_src2_rdy,
    input  logic [NUM_WAKE-1:0]              wake_valid,
    input  logic [NUM_WAKE*TAG_W-1:0]        wake_tag,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [PAYLOAD_W-1:0]             issue_payload,
    output logic [$clog2(NUM_ENTRIES):0]     occupancy
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(NUM_ENTRIES);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rdy;
    } src_t;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        src_t                 src1;
        src_t                 src2;
    } entry_t;

    logic [NUM_ENTRIES-1:0] valid_q;
    entry_t                 entry_q [NUM_ENTRIES];
    // age_q[i][j] set means entry i is older than entry j
    logic [NUM_ENTRIES-1:0] age_q   [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] cand;
    logic [NUM_ENTRIES-1:0] sel;
    logic [IDX_W-1:0]       free_idx;
    logic                   disp_fire;
    logic                   issue_fire;
    entry_t                 new_entry;

    function automatic logic tag_woken(input logic [NUM_WAKE-1:0]       wv,
                                       input logic [NUM_WAKE*TAG_W-1:0] wt,
                                       input logic [TAG_W-1:0]          tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKE; k++) begin
            if (wv[k] && (wt[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign disp_ready = (occupancy < FULL_CNT) && !flush;
    assign disp_fire  = disp_valid && disp_ready;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // An entry wins only if it is older than every other candidate.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cand[i] = valid_q[i] && entry_q[i].src1.rdy && entry_q[i].src2.rdy;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel[i] = cand[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if ((j != i) && cand[j] && !age_q[i][j]) sel[i] = 1'b0;
            end
        end
    end

    assign issue_valid = |cand;
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        issue_payload = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel[i]) issue_payload = issue_payload | entry_q[i].payload;
        end
    end

    // Wakeups landing in the dispatch cycle are folded into the new entry.
    always_comb begin
        new_entry.payload   = disp_payload;
        new_entry.src1.tag  = disp_src1_tag;
        new_entry.src1.rdy  = disp_src1_rdy | tag_woken(wake_valid, wake_tag, disp_src1_tag);
        new_entry.src2.tag  = disp_src2_tag;
        new_entry.src2.rdy  = disp_src2_rdy | tag_woken(wake_valid, wake_tag, disp_src2_tag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid_q[i]) begin
                    if (tag_woken(wake_valid, wake_tag, entry_q[i].src1.tag))
                        entry_q[i].src1.rdy <= 1'b1;
                    if (tag_woken(wake_valid, wake_tag, entry_q[i].src2.tag))
                        entry_q[i].src2.rdy <= 1'b1;
                end
                if (issue_fire && sel[i]) valid_q[i] <= 1'b0;
            end
            if (disp_fire) begin
                valid_q[free_idx] <= 1'b1;
                entry_q[free_idx] <= new_entry;
                age_q[free_idx]   <= '0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    age_q[j][free_idx] <= valid_q[j];
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_queue_select.sv
// Bench for issue_queue_select: directed scenarios plus random traffic against an age-ordered list model.
module tb_issue_queue_select;
    localparam int NE = 8;
    localparam int TW = 6;
    localparam int PW = 64;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst, flush, disp_valid, disp_ready;
    logic [PW-1:0]   disp_payload;
    logic [TW-1:0]   disp_src1_tag, disp_src2_tag;
    logic            disp_src1_rdy, disp_src2_rdy;
    logic [NW-1:0]   wake_valid;
    logic [NW*TW-1:0] wake_tag;
    logic            issue_valid, issue_ready;
    logic [PW-1:0]   issue_payload;
    logic [3:0]      occupancy;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [PW-1:0] payload;
        logic [TW-1:0] t1;
        logic          r1;
        logic [TW-1:0] t2;
        logic          r2;
    } ent_t;

    // Oldest entry at the front; slot positions inside the DUT are irrelevant here.
    ent_t mq[$];

    issue_queue_select #(.NUM_ENTRIES(NE), .TAG_W(TW), .PAYLOAD_W(PW), .NUM_WAKE(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
        .wake_valid(wake_valid), .wake_tag(wake_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_payload(issue_payload), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic woken(input logic [TW-1:0] t);
        for (int k = 0; k < NW; k++)
            if (wake_valid[k] && wake_tag[k*TW +: TW] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int first_ready();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    function automatic logic m_ivalid();
        return first_ready() >= 0;
    endfunction

    function automatic logic [PW-1:0] m_payload();
        int s;
        s = first_ready();
        return (s < 0) ? '0 : mq[s].payload;
    endfunction

    function automatic logic m_drdy();
        return (mq.size() < NE) && !flush;
    endfunction

    // Advance the model with the inputs as they stand, then cross one clock edge.
    task automatic tick();
        ent_t e;
        int   s;
        logic acc;
        s   = first_ready();
        acc = disp_valid && (mq.size() < NE) && !flush;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (issue_ready && s >= 0) mq.delete(s);
            foreach (mq[i]) begin
                if (woken(mq[i].t1)) mq[i].r1 = 1'b1;
                if (woken(mq[i].t2)) mq[i].r2 = 1'b1;
            end
            if (acc) begin
                e.payload = disp_payload;
                e.t1 = disp_src1_tag;
                e.r1 = disp_src1_rdy | woken(disp_src1_tag);
                e.t2 = disp_src2_tag;
                e.r2 = disp_src2_rdy | woken(disp_src2_tag);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; disp_valid = 0; disp_payload = '0;
        disp_src1_tag = '0; disp_src1_rdy = 0; disp_src2_tag = '0; disp_src2_rdy = 0;
        wake_valid = '0; wake_tag = '0; issue_ready = 0;
    endtask

    task automatic set_disp(input logic [PW-1:0] p, input logic [TW-1:0] t1, input logic r1,
                            input logic [TW-1:0] t2, input logic r2);
        disp_valid = 1; disp_payload = p;
        disp_src1_tag = t1; disp_src1_rdy = r1; disp_src2_tag = t2; disp_src2_rdy = r2;
    endtask

    task automatic push(input logic [PW-1:0] p, input logic [TW-1:0] t1, input logic r1,
                        input logic [TW-1:0] t2, input logic r2);
        set_disp(p, t1, r1, t2, r2);
        tick();
        disp_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0; #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_drdy: got %b want 1", disp_ready); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ivalid: got %b want 0", issue_valid); end
        n_cmp++; if (issue_payload !== 64'h0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", issue_payload); end
    endtask

    task automatic test_single();
        issue_ready = 1;
        push(64'hA0A0_0001, 6'd1, 1'b1, 6'd2, 1'b1);
        #1;
        n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL single_ivalid: got %b want 1", issue_valid); end
        n_cmp++; if (issue_payload !== 64'hA0A0_0001) begin n_fail++; $display("FAIL single_payload: got %h want a0a00001", issue_payload); end
        n_cmp++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL single_occ1: got %0d want 1", occupancy); end
        tick();
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL single_occ0: got %0d want 0", occupancy); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", issue_valid); end
        issue_ready = 0;
    endtask

    task automatic test_age_order();
        issue_ready = 1;
        push(64'hAAAA, 6'd5, 1'b0, 6'd3, 1'b1);
        push(64'hBBBB, 6'd6, 1'b1, 6'd7, 1'b1);
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd5};
        #1;
        n_cmp++; if (issue_payload !== 64'hBBBB) begin n_fail++; $display("FAIL age_first: got %h want bbbb", issue_payload); end
        tick();
        wake_valid = '0;
        #1;
        n_cmp++; if (issue_payload !== 64'hAAAA) begin n_fail++; $display("FAIL age_second: got %h want aaaa", issue_payload); end
        tick();
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL age_drain: got %0d want 0", occupancy); end
        issue_ready = 0;
    endtask

    task automatic test_bypass();
        issue_ready = 1;
        set_disp(64'hC0DE, 6'd4, 1'b1, 6'd9, 1'b0);
        wake_valid = 2'b10; wake_tag = {6'd9, 6'd0};
        tick();
        disp_valid = 0; wake_valid = '0;
        #1;
        n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_ivalid: got %b want 1", issue_valid); end
        n_cmp++; if (issue_payload !== 64'hC0DE) begin n_fail++; $display("FAIL bypass_payload: got %h want c0de", issue_payload); end
        tick();
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL bypass_drain: got %0d want 0", occupancy); end
        issue_ready = 0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < NE; i++) push(64'h100 + 64'(i), 6'(16 + i), 1'b0, 6'd0, 1'b1);
        n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occ: got %0d want 8", occupancy); end
        n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_drdy: got %b want 0", disp_ready); end
        push(64'h999, 6'd30, 1'b1, 6'd31, 1'b1);
        n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_drop: got %0d want 8", occupancy); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_dropvalid: got %b want 0", issue_valid); end
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd19};
        tick();
        wake_valid = '0; issue_ready = 1;
        #1;
        n_cmp++; if (issue_payload !== 64'h103) begin n_fail++; $display("FAIL full_sel: got %h want 103", issue_payload); end
        n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_drdy_pre: got %b want 0", disp_ready); end
        tick();
        issue_ready = 0;
        n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_drdy_post: got %b want 1", disp_ready); end
        n_cmp++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL full_occ7: got %0d want 7", occupancy); end
    endtask

    task automatic test_hold();
        do_reset();
        issue_ready = 0;
        push(64'hC, 6'd1, 1'b1, 6'd1, 1'b1);
        push(64'hD, 6'd2, 1'b1, 6'd2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (issue_payload !== 64'hC) begin n_fail++; $display("FAIL hold_c%0d: got %h want c", c, issue_payload); end
            tick();
        end
        issue_ready = 1;
        #1;
        n_cmp++; if (issue_payload !== 64'hC) begin n_fail++; $display("FAIL hold_issue_c: got %h want c", issue_payload); end
        tick();
        n_cmp++; if (issue_payload !== 64'hD) begin n_fail++; $display("FAIL hold_issue_d: got %h want d", issue_payload); end
        tick();
        n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL hold_empty: got %b want 0", issue_valid); end
        issue_ready = 0;
    endtask

    task automatic test_flush();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            push(64'hE0, 6'd1, 1'b1, 6'd1, 1'b1);
            for (int i = 1; i < 5; i++) push(64'hE0 + 64'(i), 6'(20 + i), 1'b0, 6'd0, 1'b1);
            set_disp(64'hEF, 6'd2, 1'b1, 6'd2, 1'b1);
            wake_valid = 2'b01; wake_tag = {6'd0, 6'd21};
            issue_ready = 1;
            if (pass == 0) flush = 1; else rst = 1;
            #1;
            n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL flush%0d_pre_ivalid: got %b want 1", pass, issue_valid); end
            n_cmp++; if (disp_ready !== m_drdy()) begin n_fail++; $display("FAIL flush%0d_pre_drdy: got %b want %b", pass, disp_ready, m_drdy()); end
            tick();
            flush = 0; rst = 0; disp_valid = 0; wake_valid = '0; issue_ready = 0;
            #1;
            n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush%0d_occ: got %0d want 0", pass, occupancy); end
            n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush%0d_ivalid: got %b want 0", pass, issue_valid); end
            n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL flush%0d_drdy: got %b want 1", pass, disp_ready); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            disp_valid    = ($urandom_range(0, 9) < 6);
            disp_payload  = {$urandom, $urandom};
            disp_src1_tag = 6'($urandom_range(0, 7));
            disp_src1_rdy = $urandom_range(0, 1);
            disp_src2_tag = 6'($urandom_range(0, 7));
            disp_src2_rdy = $urandom_range(0, 1);
            for (int k = 0; k < NW; k++) begin
                wake_valid[k] = ($urandom_range(0, 9) < 3);
                wake_tag[k*TW +: TW] = 6'($urandom_range(0, 7));
            end
            issue_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            n_cmp++; if (occupancy !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy, mq.size()); end
            n_cmp++; if (disp_ready !== m_drdy()) begin n_fail++; $display("FAIL rnd_drdy c%0d: got %b want %b", c, disp_ready, m_drdy()); end
            n_cmp++; if (issue_valid !== m_ivalid()) begin n_fail++; $display("FAIL rnd_ivalid c%0d: got %b want %b", c, issue_valid, m_ivalid()); end
            n_cmp++; if (issue_payload !== m_payload()) begin n_fail++; $display("FAIL rnd_payload c%0d: got %h want %h", c, issue_payload, m_payload()); end
            tick();
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_age_order();
        test_bypass();
        test_full();
        test_hold();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
